// File: rtl/csr_commit_ctrl.sv
// csr_commit_ctrl: commit-side CSR read-modify-write sequencer.
// Reads the buffered CSR, writes the merged value, acks the scoreboard.
module csr_commit_ctrl #(
  parameter int TRANS_ID_BITS = 3,
  parameter int TIMEOUT       = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     commit_valid_i,
  input  logic [1:0]               commit_op_i,
  input  logic [63:0]              commit_wdata_i,
  input  logic [TRANS_ID_BITS-1:0] commit_trans_id_i,
  input  logic [11:0]              csr_addr_i,
  output logic                     ready_o,
  output logic                     commit_ack_o,
  output logic [63:0]              commit_rdata_o,
  output logic [TRANS_ID_BITS-1:0] commit_trans_id_o,
  output logic                     exception_o,
  output logic                     exc_timeout_o,
  output logic                     csr_commit_o,
  output logic                     csr_req_o,
  output logic                     csr_we_o,
  output logic [11:0]              csr_addr_o,
  output logic [63:0]              csr_wdata_o,
  input  logic                     csr_gnt_i,
  input  logic                     csr_rvalid_i,
  input  logic [63:0]              csr_rdata_i,
  input  logic                     csr_illegal_i
);

  localparam int CW = $clog2(TIMEOUT) + 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  localparam logic [1:0] OP_RW = 2'b00;
  localparam logic [1:0] OP_RS = 2'b01;
  localparam logic [1:0] OP_RC = 2'b10;
  localparam logic [1:0] OP_RO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                   r_state;
  state_t                   w_next;
  logic [CW-1:0]            r_cnt;
  logic [1:0]               r_op;
  logic [63:0]              r_wdata;
  logic [TRANS_ID_BITS-1:0] r_tid;
  logic [11:0]              r_addr;
  logic [63:0]              r_old;
  logic [63:0]              r_new;
  logic                     r_exc;
  logic                     r_tmo;

  logic        w_cap_in;
  logic        w_cap_old;
  logic        w_cnt_clr;
  logic        w_cnt_inc;
  logic        w_set_exc;
  logic        w_set_tmo;
  logic [63:0] w_new;

  always_comb begin
    w_new = csr_rdata_i;
    unique case (r_op)
      OP_RW: w_new = r_wdata;
      OP_RS: w_new = csr_rdata_i | r_wdata;
      OP_RC: w_new = csr_rdata_i & ~r_wdata;
      OP_RO: w_new = csr_rdata_i;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next            = r_state;
    w_cap_in          = 1'b0;
    w_cap_old         = 1'b0;
    w_cnt_clr         = 1'b0;
    w_cnt_inc         = 1'b0;
    w_set_exc         = 1'b0;
    w_set_tmo         = 1'b0;
    ready_o           = 1'b0;
    commit_ack_o      = 1'b0;
    commit_rdata_o    = '0;
    commit_trans_id_o = '0;
    exception_o       = 1'b0;
    exc_timeout_o     = 1'b0;
    csr_commit_o      = 1'b0;
    csr_req_o         = 1'b0;
    csr_we_o          = 1'b0;
    csr_addr_o        = '0;
    csr_wdata_o       = '0;
    unique case (r_state)
      S_IDLE: begin
        ready_o = 1'b1;
        if (commit_valid_i) begin
          w_cap_in  = 1'b1;
          w_cnt_clr = 1'b1;
          w_next    = S_READ;
        end
      end
      S_READ: begin
        csr_req_o  = 1'b1;
        csr_addr_o = r_addr;
        if (csr_rvalid_i) begin
          w_cap_old = 1'b1;
          if (csr_illegal_i) begin
            w_set_exc = 1'b1;
            w_next    = S_RESP;
          end else if (r_op == OP_RO) begin
            w_next = S_RESP;
          end else begin
            w_cnt_clr = 1'b1;
            w_next    = S_WRITE;
          end
        end else if (r_cnt == LAST) begin
          w_set_exc = 1'b1;
          w_set_tmo = 1'b1;
          w_next    = S_RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_WRITE: begin
        csr_req_o   = 1'b1;
        csr_we_o    = 1'b1;
        csr_addr_o  = r_addr;
        csr_wdata_o = r_new;
        if (csr_gnt_i) begin
          w_next = S_RESP;
        end else if (r_cnt == LAST) begin
          w_set_exc = 1'b1;
          w_set_tmo = 1'b1;
          w_next    = S_RESP;
        end else begin
          w_cnt_inc = 1'b1;
        end
      end
      S_RESP: begin
        commit_ack_o      = 1'b1;
        csr_commit_o      = 1'b1;
        commit_rdata_o    = r_exc ? 64'd0 : r_old;
        commit_trans_id_o = r_tid;
        exception_o       = r_exc;
        exc_timeout_o     = r_tmo;
        w_next            = S_IDLE;
      end
    endcase
    // Flush kills the handshake pulses but leaves the bus view intact
    if (flush_i) begin
      w_next            = S_IDLE;
      w_cap_in          = 1'b0;
      w_cap_old         = 1'b0;
      commit_ack_o      = 1'b0;
      csr_commit_o      = 1'b0;
      commit_rdata_o    = '0;
      commit_trans_id_o = '0;
      exception_o       = 1'b0;
      exc_timeout_o     = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt   <= '0;
      r_op    <= '0;
      r_wdata <= '0;
      r_tid   <= '0;
      r_addr  <= '0;
      r_old   <= '0;
      r_new   <= '0;
      r_exc   <= 1'b0;
      r_tmo   <= 1'b0;
    end else begin
      if (w_cnt_clr) begin
        r_cnt <= '0;
      end else if (w_cnt_inc) begin
        r_cnt <= r_cnt + CW'(1);
      end
      if (w_cap_in) begin
        r_op    <= commit_op_i;
        r_wdata <= commit_wdata_i;
        r_tid   <= commit_trans_id_i;
        r_addr  <= csr_addr_i;
        r_old   <= '0;
        r_exc   <= 1'b0;
        r_tmo   <= 1'b0;
      end
      if (w_cap_old) begin
        r_old <= csr_rdata_i;
        r_new <= w_new;
      end
      if (w_set_exc) begin
        r_exc <= 1'b1;
      end
      if (w_set_tmo) begin
        r_tmo <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_csr_commit_ctrl.sv
// tb_csr_commit_ctrl: directed bench with a per-transaction timeline model.
// The model derives every cycle's expected outputs from op, delays and aborts.
module tb_csr_commit_ctrl;

  localparam int TMO = 16;

  logic        clk_i;
  logic        rst_i;
  logic        flush_i;
  logic        commit_valid_i;
  logic [1:0]  commit_op_i;
  logic [63:0] commit_wdata_i;
  logic [2:0]  commit_trans_id_i;
  logic [11:0] csr_addr_i;
  logic        ready_o;
  logic        commit_ack_o;
  logic [63:0] commit_rdata_o;
  logic [2:0]  commit_trans_id_o;
  logic        exception_o;
  logic        exc_timeout_o;
  logic        csr_commit_o;
  logic        csr_req_o;
  logic        csr_we_o;
  logic [11:0] csr_addr_o;
  logic [63:0] csr_wdata_o;
  logic        csr_gnt_i;
  logic        csr_rvalid_i;
  logic [63:0] csr_rdata_i;
  logic        csr_illegal_i;

  csr_commit_ctrl #(
    .TRANS_ID_BITS(3),
    .TIMEOUT(TMO)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .flush_i(flush_i),
    .commit_valid_i(commit_valid_i),
    .commit_op_i(commit_op_i),
    .commit_wdata_i(commit_wdata_i),
    .commit_trans_id_i(commit_trans_id_i),
    .csr_addr_i(csr_addr_i),
    .ready_o(ready_o),
    .commit_ack_o(commit_ack_o),
    .commit_rdata_o(commit_rdata_o),
    .commit_trans_id_o(commit_trans_id_o),
    .exception_o(exception_o),
    .exc_timeout_o(exc_timeout_o),
    .csr_commit_o(csr_commit_o),
    .csr_req_o(csr_req_o),
    .csr_we_o(csr_we_o),
    .csr_addr_o(csr_addr_o),
    .csr_wdata_o(csr_wdata_o),
    .csr_gnt_i(csr_gnt_i),
    .csr_rvalid_i(csr_rvalid_i),
    .csr_rdata_i(csr_rdata_i),
    .csr_illegal_i(csr_illegal_i)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        ready;
    logic        ack;
    logic        commit;
    logic        req;
    logic        we;
    logic        exc;
    logic        tmo;
    logic [11:0] addr;
    logic [63:0] wdata;
    logic [63:0] rdata;
    logic [2:0]  tid;
  } exp_t;

  exp_t e;
  bit   chk_en = 1'b0;
  int   n_chk  = 0;
  int   n_err  = 0;
  int   cyc_n  = 0;
  int   acc_cyc = 0;
  int   ack_lat = -1;
  int   we_cnt  = 0;
  int   com_cnt = 0;
  logic [63:0] last_wr = '0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc_n, act, exp);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      cyc_n++;
      chk("ready", 64'(ready_o), 64'(e.ready));
      chk("ack", 64'(commit_ack_o), 64'(e.ack));
      chk("csr_commit", 64'(csr_commit_o), 64'(e.commit));
      chk("req", 64'(csr_req_o), 64'(e.req));
      chk("we", 64'(csr_we_o), 64'(e.we));
      chk("wdata", csr_wdata_o, e.wdata);
      if (e.req && !e.we) chk("addr", 64'(csr_addr_o), 64'(e.addr));
      if (e.ack) begin
        chk("rdata", commit_rdata_o, e.rdata);
        chk("tid", 64'(commit_trans_id_o), 64'(e.tid));
        chk("exc", 64'(exception_o), 64'(e.exc));
        chk("exc_tmo", 64'(exc_timeout_o), 64'(e.tmo));
      end
      if (ready_o && commit_valid_i && !flush_i && !rst_i) acc_cyc = cyc_n;
      if (commit_ack_o) ack_lat = cyc_n - acc_cyc;
      if (csr_we_o) we_cnt++;
      if (csr_we_o && csr_gnt_i) last_wr = csr_wdata_o;
      if (csr_commit_o) com_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  function automatic exp_t idle_exp();
    exp_t x;
    x = '{ready: 1'b1, ack: 1'b0, commit: 1'b0, req: 1'b0, we: 1'b0,
          exc: 1'b0, tmo: 1'b0, addr: '0, wdata: '0, rdata: '0, tid: '0};
    return x;
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      commit_valid_i = 1'b0;
      csr_rvalid_i   = 1'b0;
      csr_gnt_i      = 1'b0;
      csr_illegal_i  = 1'b0;
      e = idle_exp();
      tick();
    end
  endtask

  // abort_at: timeline index (1 = first READ cycle) where flush/reset hits
  task automatic run_txn(input logic [1:0] op, input logic [11:0] addr,
                         input logic [63:0] wd, input logic [63:0] old,
                         input logic ill, input int rdl, input int gdl,
                         input logic [2:0] tid, input int abort_at,
                         input logic abort_rst, input logic abort_gnt);
    int   n_rd;
    int   n_wr;
    int   idx;
    logic rd_to;
    logic do_wr;
    logic wr_to;
    logic exc;
    logic tmo;
    logic [63:0] nv;
    rd_to = (rdl >= TMO);
    n_rd  = rd_to ? TMO : rdl + 1;
    do_wr = !rd_to && !ill && (op != 2'b11);
    case (op)
      2'b00:   nv = wd;
      2'b01:   nv = old | wd;
      2'b10:   nv = old & ~wd;
      default: nv = old;
    endcase
    wr_to = do_wr && (gdl >= TMO);
    n_wr  = !do_wr ? 0 : (wr_to ? TMO : gdl + 1);
    exc   = rd_to || ill || wr_to;
    tmo   = rd_to || wr_to;
    idx   = 0;
    commit_valid_i    = 1'b1;
    commit_op_i       = op;
    commit_wdata_i    = wd;
    commit_trans_id_i = tid;
    csr_addr_i        = addr;
    csr_rvalid_i      = 1'b0;
    csr_gnt_i         = 1'b0;
    csr_illegal_i     = 1'b0;
    e = idle_exp();
    tick();
    for (int k = 0; k < n_rd; k++) begin
      idx++;
      csr_rvalid_i  = !rd_to && (k == rdl);
      csr_illegal_i = csr_rvalid_i && ill;
      csr_rdata_i   = csr_rvalid_i ? old : 64'hDEAD_BEEF_0BAD_F00D;
      e = idle_exp();
      e.ready = 1'b0;
      e.req   = 1'b1;
      e.addr  = addr;
      if (idx == abort_at) begin
        if (abort_rst) rst_i = 1'b1;
        else flush_i = 1'b1;
        tick();
        rst_i = 1'b0;
        flush_i = 1'b0;
        idle(1);
        return;
      end
      tick();
    end
    csr_rvalid_i  = 1'b0;
    csr_illegal_i = 1'b0;
    for (int k = 0; k < n_wr; k++) begin
      idx++;
      csr_gnt_i = !wr_to && (k == gdl);
      e = idle_exp();
      e.ready = 1'b0;
      e.req   = 1'b1;
      e.we    = 1'b1;
      e.addr  = addr;
      e.wdata = nv;
      if (idx == abort_at) begin
        csr_gnt_i = abort_gnt;
        if (abort_rst) rst_i = 1'b1;
        else flush_i = 1'b1;
        tick();
        rst_i = 1'b0;
        flush_i = 1'b0;
        idle(1);
        return;
      end
      tick();
    end
    csr_gnt_i = 1'b0;
    e = idle_exp();
    e.ready  = 1'b0;
    e.ack    = 1'b1;
    e.commit = 1'b1;
    e.exc    = exc;
    e.tmo    = tmo;
    e.rdata  = exc ? 64'd0 : old;
    e.tid    = tid;
    tick();
  endtask

  int w0;

  initial begin
    rst_i             = 1'b1;
    flush_i           = 1'b0;
    commit_valid_i    = 1'b0;
    commit_op_i       = '0;
    commit_wdata_i    = '0;
    commit_trans_id_i = '0;
    csr_addr_i        = '0;
    csr_gnt_i         = 1'b0;
    csr_rvalid_i      = 1'b0;
    csr_rdata_i       = '0;
    csr_illegal_i     = 1'b0;
    e = idle_exp();
    tick();
    chk_en = 1'b1;
    tick();
    rst_i = 1'b0;
    idle(1);

    // RW, then back-to-back RS and RC on the same CSR
    run_txn(2'b00, 12'h340, 64'hA, 64'h5, 1'b0, 0, 0, 3'd1, -1, 1'b0, 1'b0);
    chk("lat_rw", 64'(ack_lat), 64'd3);
    chk("wr_rw", last_wr, 64'hA);
    chk("pulses_rw", 64'(com_cnt), 64'd1);
    run_txn(2'b01, 12'h300, 64'h0F, 64'hF0, 1'b0, 0, 0, 3'd2, -1, 1'b0, 1'b0);
    chk("wr_rs", last_wr, 64'hFF);
    run_txn(2'b10, 12'h300, 64'h30, 64'hF0, 1'b0, 0, 0, 3'd3, -1, 1'b0, 1'b0);
    chk("wr_rc", last_wr, 64'hC0);

    w0 = we_cnt;
    run_txn(2'b11, 12'hC00, 64'h0, 64'h1234, 1'b0, 0, 0, 3'd4, -1, 1'b0, 1'b0);
    chk("lat_ro", 64'(ack_lat), 64'd2);
    chk("ro_no_write", 64'(we_cnt - w0), 64'd0);

    // stray bus responses while idle
    commit_valid_i = 1'b0;
    csr_rvalid_i   = 1'b1;
    csr_gnt_i      = 1'b1;
    csr_illegal_i  = 1'b1;
    e = idle_exp();
    tick();
    idle(1);

    w0 = we_cnt;
    run_txn(2'b00, 12'h7B0, 64'h77, 64'h99, 1'b1, 0, 0, 3'd5, -1, 1'b0, 1'b0);
    chk("ill_no_write", 64'(we_cnt - w0), 64'd0);

    run_txn(2'b00, 12'h341, 64'h1, 64'h2, 1'b0, 99, 0, 3'd6, -1, 1'b0, 1'b0);
    chk("lat_rd_tmo", 64'(ack_lat), 64'd17);
    run_txn(2'b00, 12'h342, 64'h55, 64'h3, 1'b0, 0, 5, 3'd7, -1, 1'b0, 1'b0);
    chk("lat_gnt5", 64'(ack_lat), 64'd8);
    chk("wr_gnt5", last_wr, 64'h55);
    run_txn(2'b11, 12'hF14, 64'h0, 64'hABC, 1'b0, 15, 0, 3'd0, -1, 1'b0, 1'b0);
    chk("lat_rd15", 64'(ack_lat), 64'd17);
    run_txn(2'b01, 12'h343, 64'h8, 64'h1, 1'b0, 3, 99, 3'd2, -1, 1'b0, 1'b0);
    chk("lat_wr_tmo", 64'(ack_lat), 64'd21);
    idle(2);

    // aborts: flush in WRITE (with and without grant), reset in READ
    w0 = com_cnt;
    run_txn(2'b00, 12'h344, 64'h11, 64'h22, 1'b0, 0, 3, 3'd3, 3, 1'b0, 1'b0);
    run_txn(2'b00, 12'h345, 64'h33, 64'h44, 1'b0, 0, 3, 3'd4, 2, 1'b0, 1'b1);
    chk("wr_flush_gnt", last_wr, 64'h33);
    run_txn(2'b00, 12'h346, 64'h55, 64'h66, 1'b0, 5, 0, 3'd5, 2, 1'b1, 1'b0);
    chk("abort_pulses", 64'(com_cnt - w0), 64'd0);

    // flush in IDLE must drop the offered commit
    commit_valid_i = 1'b1;
    commit_op_i    = 2'b00;
    csr_addr_i     = 12'h347;
    flush_i        = 1'b1;
    e = idle_exp();
    tick();
    flush_i = 1'b0;
    idle(1);

    run_txn(2'b00, 12'h348, 64'hCAFE, 64'hBEEF, 1'b0, 0, 0, 3'd6, -1, 1'b0,
            1'b0);
    chk("lat_final", 64'(ack_lat), 64'd3);
    chk("wr_final", last_wr, 64'hCAFE);
    idle(2);
    chk("total_pulses", 64'(com_cnt), 64'd10);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/csr_commit_ctrl.md
Name: csr_commit_ctrl

Overview:
- Commit-side partner of the issue-side CSR address buffer: consumes the buffered CSR address and the head-of-scoreboard CSR instruction, then performs the architectural CSR read-modify-write on the CSR file.
- When the access completes, pulses the commit strobe back to the buffer so the buffer frees its single entry.
- Returns the old CSR value to the commit stage for register writeback, or reports an exception (illegal access or access timeout).

Parameters:
- TRANS_ID_BITS, 3, width of the scoreboard transaction id (matches ariane_pkg).
- TIMEOUT, 16, maximum wait in cycles for a CSR-file read response or write grant; must be >= 2.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- flush_i  in  1  abort any in-flight operation
- commit_valid_i  in  1  head instruction is a CSR op ready to commit; held until commit_ack_o
- commit_op_i  in  2  00=RW, 01=RS (set), 10=RC (clear), 11=RO (read only)
- commit_wdata_i  in  64  source operand (buffer result, i.e. operand a)
- commit_trans_id_i  in  TRANS_ID_BITS  scoreboard id
- csr_addr_i  in  12  CSR address held by the address buffer
- ready_o  out  1  controller idle
- commit_ack_o  out  1  one-cycle completion pulse
- commit_rdata_o  out  64  old CSR value, valid with commit_ack_o
- commit_trans_id_o  out  TRANS_ID_BITS  id, valid with commit_ack_o
- exception_o  out  1  with commit_ack_o: the access faulted
- exc_timeout_o  out  1  with exception_o: 1 = timeout, 0 = illegal
- csr_commit_o  out  1  one-cycle pulse to the address buffer
- csr_req_o  out  1  CSR-file request
- csr_we_o  out  1  1 = write, 0 = read
- csr_addr_o  out  12  CSR-file address
- csr_wdata_o  out  64  CSR-file write data
- csr_gnt_i  in  1  write accepted
- csr_rvalid_i  in  1  read data valid
- csr_rdata_i  in  64  read data
- csr_illegal_i  in  1  with csr_rvalid_i: access not permitted

Behaviour:
- Reset: synchronous on rst_i; state=IDLE, counter=0, all outputs 0, ready_o=1.

FSM states: IDLE, READ, WRITE, RESP.

- IDLE: ready_o=1.
  - If commit_valid_i, capture op, wdata, trans_id and addr into registers; go to READ.
  - Inputs are not sampled again until the next IDLE.
- READ: csr_req_o=1, csr_we_o=0, csr_addr_o = captured addr.
  - When csr_rvalid_i is seen, capture csr_rdata_i as old value.
  - If csr_illegal_i: set exception, go to RESP.
  - Else if op=RO: go to RESP.
  - Else compute new value:
    - RW: new = wdata
    - RS: new = old | wdata
    - RC: new = old & ~wdata
    - then go to WRITE.
- WRITE: csr_req_o=1, csr_we_o=1, csr_wdata_o = registered new value.
  - When csr_gnt_i is seen, go to RESP.
- RESP: for exactly one cycle, commit_ack_o=1, csr_commit_o=1, commit_rdata_o = old value (0 on exception), commit_trans_id_o and exception flags driven; then go to IDLE.

Timeout:
- Counter clears on entry to READ and on entry to WRITE, and increments each cycle the awaited response is absent.
- If the response is still absent after TIMEOUT cycles: exception_o=1, exc_timeout_o=1, go to RESP with no write performed; csr_req_o drops.

Latency (immediate rvalid/gnt):
- Ack arrives 3 cycles after acceptance for RW/RS/RC, and 2 cycles for RO.
- Back-to-back commits are separated by one IDLE cycle.

Flush:
- flush_i in any state forces IDLE on the next edge.
- In the flushed cycle, commit_ack_o and csr_commit_o are suppressed (0); csr_req_o still follows the current state for that cycle.
- A write granted in the same cycle as flush is considered performed, but no ack is produced.
- flush_i in IDLE ignores commit_valid_i in that cycle.
- rst_i takes priority over flush_i.
- Reset mid-operation abandons the transaction with no pulses.

Other rules:
- csr_rvalid_i and csr_gnt_i are ignored outside READ and WRITE respectively.
- csr_illegal_i is only meaningful alongside csr_rvalid_i.
- Outputs not listed for a state are 0.

Test Plan:
- RW: addr=0x340, old=0x5, wdata=0xA, rvalid and gnt immediate -> csr_wdata_o=0xA; ack 3 cycles after accept with rdata=0x5; csr_commit_o pulses once.
- RS and RC: old=0xF0. RS with wdata=0x0F -> written 0xFF. RC with wdata=0x30 -> written 0xC0. Both return rdata=0xF0.
- RO: addr=0xC00 -> no write cycle (csr_we_o never 1); ack 2 cycles after accept.
- Illegal: rvalid with illegal=1 -> no write; ack with exception_o=1, exc_timeout_o=0, rdata=0.
- Timeout: rvalid never asserted, TIMEOUT=16 -> ack with exc_timeout_o=1 after 16 wait cycles. Then gnt delayed 5 cycles on a following RW -> normal ack.
- Flush in WRITE, and rst_i held one cycle mid-READ -> no ack, no csr_commit_o; ready_o=1 on the next cycle; a subsequent RW completes normally.
